// File: rtl/time_set_controller_pkg.sv
// Shared types and constants for the HH:MM time-setting controller.
// Digit limits and the dash code are used by both the FSM and the testbench.
package time_set_controller_pkg;

   typedef enum logic [2:0] {
      StRun,
      StEditH10,
      StEditH1,
      StEditM10,
      StEditM1
   } state_e;

   localparam logic [3:0] DIGIT_DASH = 4'hF;
   localparam logic [3:0] H10_MAX    = 4'd2;
   localparam logic [3:0] H1_MAX     = 4'd9;
   localparam logic [3:0] H1_MAX_20  = 4'd3;
   localparam logic [3:0] M10_MAX    = 4'd5;
   localparam logic [3:0] M1_MAX     = 4'd9;

   // Wraps to 0 at or above the limit so an out-of-range digit self-corrects.
   function automatic logic [3:0] bcd_inc(input logic [3:0] value, input logic [3:0] max);
      return (value >= max) ? 4'd0 : value + 4'd1;
   endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button, live-time, display and load signals between the time-setting controller
// and its neighbours (debouncers, timekeeper, segment mux).
interface time_set_controller_if;

   logic       btn_mode;
   logic       btn_next;
   logic       btn_inc;
   logic [3:0] cur_h10;
   logic [3:0] cur_h1;
   logic [3:0] cur_m10;
   logic [3:0] cur_m1;
   logic [3:0] disp0;
   logic [3:0] disp1;
   logic [3:0] disp2;
   logic [3:0] disp3;
   logic       load;
   logic [3:0] load_h10;
   logic [3:0] load_h1;
   logic [3:0] load_m10;
   logic [3:0] load_m1;
   logic       editing;

   modport master (
      output btn_mode, btn_next, btn_inc, cur_h10, cur_h1, cur_m10, cur_m1,
      input  disp0, disp1, disp2, disp3, load, load_h10, load_h1, load_m10, load_m1, editing
   );

   modport slave (
      input  btn_mode, btn_next, btn_inc, cur_h10, cur_h1, cur_m10, cur_m1,
      output disp0, disp1, disp2, disp3, load, load_h10, load_h1, load_m10, load_m1, editing
   );

endinterface

// File: rtl/time_set_controller_blink_timer.sv
// Blink prescaler, blink phase and idle half-period counter for the edit display.
// phase=0 is the visible half; timeout rises once TIMEOUT_HALFS idle toggles elapsed.
module time_set_controller_blink_timer #(
   parameter int unsigned BLINK_DIV     = 250000,
   parameter int unsigned TIMEOUT_HALFS = 40
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic restart,
   output logic phase,
   output logic timeout
);

   localparam int unsigned PrescW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned IdleW  = (TIMEOUT_HALFS > 0) ? $clog2(TIMEOUT_HALFS + 1) : 1;
   localparam logic [PrescW-1:0] PrescLast = PrescW'(BLINK_DIV - 1);
   localparam logic [IdleW-1:0]  IdleLimit = IdleW'(TIMEOUT_HALFS);

   logic [PrescW-1:0] presc_q;
   logic [IdleW-1:0]  idle_q;
   logic              phase_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         idle_q  <= '0;
         phase_q <= 1'b0;
      end else if (!enable || restart) begin
         presc_q <= '0;
         idle_q  <= '0;
         phase_q <= 1'b0;
      end else if (presc_q == PrescLast) begin
         presc_q <= '0;
         phase_q <= ~phase_q;
         // Saturate so timeout stays asserted until the FSM leaves edit.
         if (idle_q != IdleLimit) begin
            idle_q <= idle_q + 1'b1;
         end
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign phase   = phase_q;
   assign timeout = (idle_q == IdleLimit);

endmodule

// File: rtl/time_set_controller.sv
// HH:MM time-setting controller: passes live digits to the display in RUN and runs a
// four-digit edit FSM with blinking selection, increment, commit and idle timeout.
module time_set_controller
   import time_set_controller_pkg::*;
#(
   parameter int unsigned BLINK_DIV     = 250000,
   parameter int unsigned TIMEOUT_HALFS = 40
) (
   input  logic                 clock,
   input  logic                 reset_n,
   time_set_controller_if.slave bus
);

   state_e     state_q;
   logic [3:0] h10_q, h1_q, m10_q, m1_q;
   logic [3:0] disp0_q, disp1_q, disp2_q, disp3_q;
   logic [3:0] load_h10_q, load_h1_q, load_m10_q, load_m1_q;
   logic       load_q;
   logic       editing_q;
   logic       edit_active;
   logic       any_btn;
   logic       phase;
   logic       timeout;
   logic [3:0] h10_inc;

   assign edit_active = (state_q != StRun);
   assign any_btn     = bus.btn_mode | bus.btn_next | bus.btn_inc;
   assign h10_inc     = bcd_inc(h10_q, H10_MAX);

   time_set_controller_blink_timer #(
      .BLINK_DIV     (BLINK_DIV),
      .TIMEOUT_HALFS (TIMEOUT_HALFS)
   ) u_blink_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (edit_active),
      .restart (any_btn),
      .phase   (phase),
      .timeout (timeout)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StRun;
         h10_q      <= 4'd0;
         h1_q       <= 4'd0;
         m10_q      <= 4'd0;
         m1_q       <= 4'd0;
         disp0_q    <= DIGIT_DASH;
         disp1_q    <= DIGIT_DASH;
         disp2_q    <= DIGIT_DASH;
         disp3_q    <= DIGIT_DASH;
         load_q     <= 1'b0;
         load_h10_q <= 4'd0;
         load_h1_q  <= 4'd0;
         load_m10_q <= 4'd0;
         load_m1_q  <= 4'd0;
         editing_q  <= 1'b0;
      end else begin
         load_q    <= 1'b0;
         editing_q <= edit_active;
         if (state_q == StRun) begin
            disp0_q <= bus.cur_h10;
            disp1_q <= bus.cur_h1;
            disp2_q <= bus.cur_m10;
            disp3_q <= bus.cur_m1;
            if (bus.btn_mode) begin
               h10_q   <= bus.cur_h10;
               h1_q    <= bus.cur_h1;
               m10_q   <= bus.cur_m10;
               m1_q    <= bus.cur_m1;
               state_q <= StEditH10;
            end
         end else begin
            disp0_q <= (state_q == StEditH10 && phase) ? DIGIT_DASH : h10_q;
            disp1_q <= (state_q == StEditH1  && phase) ? DIGIT_DASH : h1_q;
            disp2_q <= (state_q == StEditM10 && phase) ? DIGIT_DASH : m10_q;
            disp3_q <= (state_q == StEditM1  && phase) ? DIGIT_DASH : m1_q;
            // Buttons take precedence over a coincident timeout.
            if (bus.btn_mode) begin
               load_q     <= 1'b1;
               load_h10_q <= h10_q;
               load_h1_q  <= h1_q;
               load_m10_q <= m10_q;
               load_m1_q  <= m1_q;
               state_q    <= StRun;
            end else if (bus.btn_next) begin
               case (state_q)
                  StEditH10: state_q <= StEditH1;
                  StEditH1:  state_q <= StEditM10;
                  StEditM10: state_q <= StEditM1;
                  default:   state_q <= StEditH10;
               endcase
            end else if (bus.btn_inc) begin
               case (state_q)
                  StEditH10: begin
                     h10_q <= h10_inc;
                     if (h10_inc == H10_MAX && h1_q > H1_MAX_20) begin
                        h1_q <= H1_MAX_20;
                     end
                  end
                  StEditH1:  h1_q  <= bcd_inc(h1_q, (h10_q == H10_MAX) ? H1_MAX_20 : H1_MAX);
                  StEditM10: m10_q <= bcd_inc(m10_q, M10_MAX);
                  StEditM1:  m1_q  <= bcd_inc(m1_q, M1_MAX);
                  default:   ;
               endcase
            end else if (timeout) begin
               state_q <= StRun;
            end
         end
      end
   end

   assign bus.disp0    = disp0_q;
   assign bus.disp1    = disp1_q;
   assign bus.disp2    = disp2_q;
   assign bus.disp3    = disp3_q;
   assign bus.load     = load_q;
   assign bus.load_h10 = load_h10_q;
   assign bus.load_h1  = load_h1_q;
   assign bus.load_m10 = load_m10_q;
   assign bus.load_m1  = load_m1_q;
   assign bus.editing  = editing_q;

endmodule
